delay_code_stepper: RTL and testbench

Controller that owns the 12-bit delay code `k_sgn` = {coarse tap select[11:7], fine delay control[6:0]} driving the converter's tap mux and fine delay generator. It accepts a target code from a requester over a valid/ready handshake. It walks the live code toward the target one LSB at a time, with a programmable settle interval after each step, so the converter output never sees a large tap jump. It sits between the calibration/configuration logic and the converter.

---
 rtl/delay_code_stepper_pkg.sv | 8 +
 rtl/delay_code_stepper_settle_timer.sv | 15 +
 rtl/delay_code_stepper.sv | 54 +++++
 tb/tb_delay_code_stepper.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/delay_code_stepper_pkg.sv
// delay_code_stepper_pkg: shared code widths, settle counter width and FSM state encoding
package delay_code_stepper_pkg;
  localparam int DEF_COARSE_W = 5;
  localparam int DEF_FINE_W = 7;
  localparam int CODE_W = DEF_COARSE_W + DEF_FINE_W;
  localparam int SETTLE_W = 8;
  typedef enum logic [1:0] {IDLE, STEP, SETTLE} state_t;
endpackage

// File: rtl/delay_code_stepper_settle_timer.sv
// delay_code_stepper_settle_timer: loadable settle down-counter with freeze input and zero flag
module delay_code_stepper_settle_timer import delay_code_stepper_pkg::*; (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                freeze,
  input  logic [SETTLE_W-1:0] load_val,
  output logic                zero
);
  logic [SETTLE_W-1:0] count;
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else count <= load ? load_val : (freeze || zero) ? count : count - 1'b1;
  assign zero = count == '0;
endmodule

// File: rtl/delay_code_stepper.sv
// delay_code_stepper: walks the live delay code toward a requested target one LSB per settle interval
module delay_code_stepper import delay_code_stepper_pkg::*; #(
  parameter int COARSE_W = DEF_COARSE_W,
  parameter int FINE_W = DEF_FINE_W,
  parameter int SETTLE = 8,
  parameter logic [COARSE_W+FINE_W-1:0] RESET_CODE = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  input  logic [COARSE_W+FINE_W-1:0] req_code,
  output logic                       req_ready,
  input  logic                       hold,
  output logic [COARSE_W+FINE_W-1:0] k_sgn,
  output logic                       step_strobe,
  output logic                       busy,
  output logic                       done
);
  state_t state, state_nxt;
  logic [COARSE_W+FINE_W-1:0] target;
  logic zero, accept, arrive;
  assign accept = state == IDLE && req_valid;
  assign arrive = state == delay_code_stepper_pkg::SETTLE && zero && !hold && k_sgn == target;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == IDLE ? ((accept && req_code != k_sgn) ? STEP : IDLE) :
                state == STEP ? delay_code_stepper_pkg::SETTLE :
                (zero && !hold) ? ((k_sgn == target) ? IDLE : STEP) : delay_code_stepper_pkg::SETTLE;
  always_comb begin
    req_ready = state == IDLE;
    busy = state != IDLE;
    step_strobe = state == STEP;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      k_sgn <= RESET_CODE;
      target <= RESET_CODE;
      done <= 1'b0;
    end else begin
      if (accept) target <= req_code;
      if (step_strobe) k_sgn <= (target > k_sgn) ? k_sgn + 1'b1 : k_sgn - 1'b1;
      done <= (accept && req_code == k_sgn) || arrive;
    end
  delay_code_stepper_settle_timer settle_timer (
    .clk(clk),
    .rst(rst),
    .load(step_strobe),
    .freeze(hold),
    .load_val(SETTLE_W'(SETTLE - 1)),
    .zero(zero)
  );
endmodule

// File: tb/tb_delay_code_stepper.sv
// tb_delay_code_stepper: scoreboard-driven bench for the delay code stepper
module tb_delay_code_stepper;
  localparam int ST = 4;
  logic clk = 0, rst = 1, req_valid = 0, hold = 0;
  logic [11:0] req_code = '0;
  logic req_ready, step_strobe, busy, done;
  logic [11:0] k_sgn, prev = '0, model = '0;
  int checks = 0, errors = 0, cyc = 0, last_chg = 0;
  typedef struct {logic [11:0] code; int gap;} exp_t;
  exp_t sb[$];
  delay_code_stepper #(.COARSE_W(5), .FINE_W(7), .SETTLE(ST), .RESET_CODE(12'h000)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_code(req_code), .req_ready(req_ready),
    .hold(hold), .k_sgn(k_sgn), .step_strobe(step_strobe), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      prev = k_sgn;
      last_chg = cyc;
    end else if (k_sgn !== prev) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_step k_sgn=%h", k_sgn);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (k_sgn !== e.code || (e.gap != 0 && cyc - last_chg != e.gap)) begin
          errors++;
          $display("FAIL step k_sgn=%h gap=%0d expected %h gap=%0d", k_sgn, cyc - last_chg, e.code, e.gap);
        end
      end
      prev = k_sgn;
      last_chg = cyc;
    end
  end
  task automatic push_walk(input logic [11:0] from, input logic [11:0] to);
    logic [11:0] c;
    bit first;
    c = from;
    first = 1;
    while (c != to) begin
      c = (to > c) ? c + 12'd1 : c - 12'd1;
      sb.push_back('{code: c, gap: first ? 0 : ST + 1});
      first = 0;
    end
  endtask
  task automatic send(input logic [11:0] code);
    push_walk(model, code);
    model = code;
    req_code = code;
    req_valid = 1;
    @(posedge clk);
    #1 req_valid = 0;
  endtask
  task automatic run_until_done(input int limit, output int nbusy, output int nstrobe, output int ncyc, output bit seen);
    nbusy = 0;
    nstrobe = 0;
    ncyc = 0;
    seen = 0;
    while (!seen && ncyc < limit) begin
      @(negedge clk);
      ncyc++;
      if (busy) nbusy++;
      if (step_strobe) nstrobe++;
      if (done) seen = 1;
    end
  endtask
  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    checks++;
    if ({k_sgn, req_ready, busy, done, step_strobe} !== {12'h000, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset k=%h rdy=%b busy=%b done=%b strobe=%b expected 000 1 0 0 0", k_sgn, req_ready, busy, done, step_strobe);
    end
  endtask
  task automatic test_walk_up;
    int nb, ns, nc;
    bit seen;
    send(12'h003);
    run_until_done(200, nb, ns, nc, seen);
    checks++;
    if (!seen || nb != 3 * (ST + 1) || ns != 3) begin
      errors++;
      $display("FAIL walk_up seen=%b busy=%0d strobes=%0d expected 1 %0d 3", seen, nb, ns, 3 * (ST + 1));
    end
    checks++;
    if (k_sgn !== 12'h003 || req_ready !== 1'b1 || sb.size() != 0) begin
      errors++;
      $display("FAIL walk_up_end k=%h rdy=%b pending=%0d expected 003 1 0", k_sgn, req_ready, sb.size());
    end
  endtask
  task automatic test_coarse_carry;
    int nb, ns, nc;
    bit seen;
    send(12'h07E);
    run_until_done(2000, nb, ns, nc, seen);
    checks++;
    if (!seen || k_sgn !== 12'h07E) begin
      errors++;
      $display("FAIL approach seen=%b k=%h expected 1 07e", seen, k_sgn);
    end
    send(12'h081);
    run_until_done(200, nb, ns, nc, seen);
    checks++;
    if (!seen || nb != 3 * (ST + 1) || k_sgn !== 12'h081) begin
      errors++;
      $display("FAIL carry_up seen=%b busy=%0d k=%h expected 1 %0d 081", seen, nb, k_sgn, 3 * (ST + 1));
    end
    send(12'h07E);
    run_until_done(200, nb, ns, nc, seen);
    checks++;
    if (!seen || nb != 3 * (ST + 1) || k_sgn !== 12'h07E || sb.size() != 0) begin
      errors++;
      $display("FAIL borrow_down seen=%b busy=%0d k=%h pending=%0d expected 1 %0d 07e 0", seen, nb, k_sgn, sb.size(), 3 * (ST + 1));
    end
  endtask
  task automatic test_equal;
    int nb, ns, nc;
    bit seen;
    send(model);
    run_until_done(20, nb, ns, nc, seen);
    checks++;
    if (!seen || nc != 1 || nb != 0 || ns != 0 || k_sgn !== 12'h07E) begin
      errors++;
      $display("FAIL equal seen=%b wait=%0d busy=%0d strobes=%0d k=%h expected 1 1 0 0 07e", seen, nc, nb, ns, k_sgn);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_width done=%b expected 0", done);
    end
  endtask
  task automatic test_back_to_back;
    int nb, ns, nc, pre;
    bit seen;
    send(12'h081);
    pre = 0;
    repeat (3) begin @(negedge clk); if (busy) pre++; end
    req_code = 12'h000;
    req_valid = 1;
    repeat (2) begin @(negedge clk); if (busy) pre++; end
    req_valid = 0;
    run_until_done(200, nb, ns, nc, seen);
    checks++;
    if (!seen || pre + nb != 3 * (ST + 1) || k_sgn !== 12'h081 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ignore_busy seen=%b busy=%0d k=%h rdy=%b expected 1 %0d 081 1", seen, pre + nb, k_sgn, req_ready, 3 * (ST + 1));
    end
  endtask
  task automatic test_hold;
    int nb, ns, nc, pre, guard;
    bit seen;
    send(12'h083);
    sb[sb.size() - 1].gap = ST + 1 + 10;
    pre = 0;
    guard = 0;
    do begin @(negedge clk); if (busy) pre++; guard++; end while (k_sgn !== 12'h082 && guard < 50);
    hold = 1;
    repeat (10) begin @(negedge clk); if (busy) pre++; end
    hold = 0;
    run_until_done(200, nb, ns, nc, seen);
    checks++;
    if (!seen || pre + nb != 2 * (ST + 1) + 10 || k_sgn !== 12'h083 || sb.size() != 0) begin
      errors++;
      $display("FAIL hold seen=%b busy=%0d k=%h pending=%0d expected 1 %0d 083 0", seen, pre + nb, k_sgn, sb.size(), 2 * (ST + 1) + 10);
    end
  endtask
  task automatic test_reset_mid;
    int nb, ns, nc, guard, noise;
    bit seen;
    send(12'h030);
    run_until_done(2000, nb, ns, nc, seen);
    send(12'h050);
    guard = 0;
    do begin @(negedge clk); guard++; end while (k_sgn !== 12'h040 && guard < 500);
    checks++;
    if (k_sgn !== 12'h040) begin
      errors++;
      $display("FAIL reach_040 k=%h expected 040", k_sgn);
    end
    rst = 1;
    #1;
    checks++;
    if ({k_sgn, req_ready, busy, done, step_strobe} !== {12'h000, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset k=%h rdy=%b busy=%b done=%b strobe=%b expected 000 1 0 0 0", k_sgn, req_ready, busy, done, step_strobe);
    end
    model = 12'h000;
    repeat (2) @(negedge clk);
    rst = 0;
    noise = 0;
    repeat (40) begin @(negedge clk); if (busy || step_strobe || done || k_sgn !== 12'h000) noise++; end
    checks++;
    if (noise != 0) begin
      errors++;
      $display("FAIL post_reset_quiet active_cycles=%0d expected 0", noise);
    end
  endtask
  initial begin
    test_reset;
    test_walk_up;
    test_coarse_carry;
    test_equal;
    test_back_to_back;
    test_hold;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
